// File: rtl/squash_arbiter_pkg.sv
// Shared types for the squash arbiter: instruction id/pc, squash request record, FSM states.
// Age helper keeps id wrap-around handling in exactly one place.
package squash_arbiter_pkg;

   localparam int ID_W  = 8;
   localparam int PC_W  = 32;
   localparam int CNT_W = 4;

   typedef logic [ID_W-1:0] id_t;
   typedef logic [PC_W-1:0] pc_t;

   typedef struct packed {
      id_t id;
      pc_t pc;
   } squash_req_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SQUASH = 2'd1,
      DRAIN  = 2'd2
   } squash_state_e;

   // Distance from the oldest in-flight instruction; modular subtraction absorbs id wrap.
   function automatic id_t id_age(input id_t x, input id_t head);
      return id_t'(x - head);
   endfunction

endpackage

// File: rtl/squash_arbiter_oldest_sel.sv
// Combinational age-based pick of the oldest valid squash request; ties go to the lowest index.
// Zero latency, no backpressure.
module oldest_sel
   import squash_arbiter_pkg::*;
#(
   parameter int NREQ  = 3,
   parameter int IDX_W = 2
) (
   input  logic        [NREQ-1:0] valid,
   input  squash_req_t [NREQ-1:0] req,
   input  id_t                    head_id,
   output logic                   win_vld,
   output logic       [IDX_W-1:0] win_idx,
   output squash_req_t            win_req
);

   id_t best_age;

   always_comb begin
      win_vld  = 1'b0;
      win_idx  = '0;
      win_req  = '0;
      best_age = '0;
      // Strict compare keeps the earlier (lower) index on equal ages.
      for (int i = 0; i < NREQ; i++) begin
         if (valid[i] && (!win_vld || (id_age(req[i].id, head_id) < best_age))) begin
            win_vld  = 1'b1;
            win_idx  = IDX_W'(i);
            win_req  = req[i];
            best_age = id_age(req[i].id, head_id);
         end
      end
   end

endmodule

// File: rtl/squash_arbiter.sv
// Arbitrates pipeline squash requests by age, emits one squash+redirect pulse and stalls the front end.
// Latency 1 cycle from request to pulse (2 if preempting during the SQUASH cycle); requests are never backpressured.
module squash_arbiter
   import squash_arbiter_pkg::*;
#(
   parameter int NREQ         = 3,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req_valid_i,
   input  id_t  [NREQ-1:0] req_id_i,
   input  pc_t  [NREQ-1:0] req_pc_i,
   input  id_t             head_id_i,
   output logic            squash_valid_o,
   output id_t             squash_id_o,
   output logic            redirect_valid_o,
   output pc_t             redirect_pc_o,
   output logic            stall_o,
   output logic            busy_o
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   squash_state_e state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   squash_req_t lat, lat_nxt;
   logic pend, pend_nxt;

   squash_req_t [NREQ-1:0] req_arr;
   logic              win_vld;
   logic  [IDX_W-1:0] win_idx;
   squash_req_t       win_req;
   logic              accept;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req_arr[i].id = req_id_i[i];
         req_arr[i].pc = req_pc_i[i];
      end
   end

   oldest_sel #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_oldest_sel (
      .valid   (req_valid_i),
      .req     (req_arr),
      .head_id (head_id_i),
      .win_vld (win_vld),
      .win_idx (win_idx),
      .win_req (win_req)
   );

   // Once busy, only a strictly older winner can redirect again; everything else is already squashed.
   assign accept = win_vld && req_valid_i[win_idx] &&
                   ((state == IDLE) ||
                    (id_age(win_req.id, head_id_i) < id_age(lat.id, head_id_i)));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      lat_nxt   = lat;
      pend_nxt  = pend;
      case (state)
         IDLE: begin
            if (accept) begin
               lat_nxt   = win_req;
               state_nxt = SQUASH;
            end
         end
         SQUASH: begin
            // A preemption arriving on the pulse cycle is held for one DRAIN cycle so pulses never abut.
            state_nxt = DRAIN;
            cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
            if (accept) begin
               lat_nxt  = win_req;
               pend_nxt = 1'b1;
            end
         end
         DRAIN: begin
            if (accept || pend) begin
               if (accept) lat_nxt = win_req;
               pend_nxt  = 1'b0;
               state_nxt = SQUASH;
            end else if (cnt == '0) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         lat   <= '0;
         pend  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         lat   <= lat_nxt;
         pend  <= pend_nxt;
      end
   end

   assign squash_valid_o   = (state == SQUASH);
   assign redirect_valid_o = (state == SQUASH);
   assign squash_id_o      = lat.id;
   assign redirect_pc_o    = lat.pc;
   assign stall_o          = (state != IDLE);
   assign busy_o           = (state != IDLE);

endmodule

// File: tb/tb_squash_arbiter.sv
// Directed bench for squash_arbiter: reset, age arbitration, wrap, tie-break, drop/preempt, reset abort.
module tb_squash_arbiter;
   import squash_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic  [2:0] req_valid;
   id_t   [2:0] req_id;
   pc_t   [2:0] req_pc;
   id_t         head_id;
   logic        squash_valid, redirect_valid, stall, busy;
   id_t         squash_id;
   pc_t         redirect_pc;

   int n_checks = 0;
   int n_fail   = 0;

   squash_arbiter #(.NREQ(3), .DRAIN_CYCLES(2)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid_i      (req_valid),
      .req_id_i         (req_id),
      .req_pc_i         (req_pc),
      .head_id_i        (head_id),
      .squash_valid_o   (squash_valid),
      .squash_id_o      (squash_id),
      .redirect_valid_o (redirect_valid),
      .redirect_pc_o    (redirect_pc),
      .stall_o          (stall),
      .busy_o           (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      req_valid = '0;
      req_id    = '0;
      req_pc    = '0;
   endtask

   // After the SQUASH cycle: expect exactly 2 stalled DRAIN cycles, no pulse, then idle.
   task automatic finish_drain(input string name);
      int cyc = 0;
      int pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (squash_valid) pulses++;
         if (!busy) break;
         cyc++;
      end
      n_checks++;
      if (cyc !== 2) begin
         n_fail++;
         $display("FAIL %s drain_cycles: got %0d expected 2", name, cyc);
      end
      n_checks++;
      if (pulses !== 0) begin
         n_fail++;
         $display("FAIL %s extra_pulse: got %0d expected 0", name, pulses);
      end
      n_checks++;
      if (busy !== 1'b0 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL %s idle_after_drain: busy=%b stall=%b expected 0/0", name, busy, stall);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_reqs();
      head_id = 8'h10;
      tick();
      req_valid = 3'b001;
      req_id[0] = 8'h12;
      req_pc[0] = 32'h8000_0100;
      tick();
      n_checks++;
      if ({squash_valid, redirect_valid, stall, busy} !== 4'b0 || squash_id !== 8'h00 ||
          redirect_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: sv=%b rv=%b st=%b bz=%b id=%h pc=%h expected all 0",
                  squash_valid, redirect_valid, stall, busy, squash_id, redirect_pc);
      end
      rst = 1'b0;
      clear_reqs();
      tick();
      n_checks++;
      if (squash_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_req_discard: sv=%b busy=%b expected 0/0", squash_valid, busy);
      end
   endtask

   task automatic test_single();
      head_id   = 8'h10;
      req_valid = 3'b001;
      req_id[0] = 8'h12;
      req_pc[0] = 32'h8000_0100;
      tick();
      clear_reqs();
      n_checks++;
      if (squash_valid !== 1'b1 || redirect_valid !== 1'b1 || stall !== 1'b1 ||
          squash_id !== 8'h12 || redirect_pc !== 32'h8000_0100) begin
         n_fail++;
         $display("FAIL single_pulse: sv=%b rv=%b st=%b id=%h pc=%h expected 1/1/1/12/80000100",
                  squash_valid, redirect_valid, stall, squash_id, redirect_pc);
      end
      finish_drain("single");
      n_checks++;
      if (squash_id !== 8'h12 || redirect_pc !== 32'h8000_0100) begin
         n_fail++;
         $display("FAIL single_hold: id=%h pc=%h expected 12/80000100", squash_id, redirect_pc);
      end
   endtask

   task automatic test_oldest();
      head_id   = 8'h10;
      req_valid = 3'b011;
      req_id[0] = 8'h15;  req_pc[0] = 32'h0000_A000;
      req_id[1] = 8'h13;  req_pc[1] = 32'h0000_B000;
      tick();
      clear_reqs();
      n_checks++;
      if (squash_valid !== 1'b1 || squash_id !== 8'h13 || redirect_pc !== 32'h0000_B000) begin
         n_fail++;
         $display("FAIL oldest_pick: sv=%b id=%h pc=%h expected 1/13/0000b000",
                  squash_valid, squash_id, redirect_pc);
      end
      finish_drain("oldest");
   endtask

   task automatic test_wrap();
      head_id   = 8'hFE;
      req_valid = 3'b101;
      req_id[0] = 8'h01;  req_pc[0] = 32'h0000_0011;
      req_id[2] = 8'hFF;  req_pc[2] = 32'h0000_00FF;
      tick();
      clear_reqs();
      n_checks++;
      if (squash_valid !== 1'b1 || squash_id !== 8'hFF || redirect_pc !== 32'h0000_00FF) begin
         n_fail++;
         $display("FAIL wrap_pick: sv=%b id=%h pc=%h expected 1/ff/000000ff",
                  squash_valid, squash_id, redirect_pc);
      end
      finish_drain("wrap");
   endtask

   task automatic test_tie();
      head_id   = 8'h10;
      req_valid = 3'b110;
      req_id[1] = 8'h30;  req_pc[1] = 32'h0000_1111;
      req_id[2] = 8'h30;  req_pc[2] = 32'h0000_2222;
      tick();
      clear_reqs();
      n_checks++;
      if (squash_valid !== 1'b1 || squash_id !== 8'h30 || redirect_pc !== 32'h0000_1111) begin
         n_fail++;
         $display("FAIL tie_pick: sv=%b id=%h pc=%h expected 1/30/00001111",
                  squash_valid, squash_id, redirect_pc);
      end
      finish_drain("tie");
   endtask

   task automatic test_drop_preempt();
      head_id   = 8'h10;
      req_valid = 3'b001;
      req_id[0] = 8'h20;  req_pc[0] = 32'h0000_0200;
      tick();
      clear_reqs();
      tick();
      req_valid = 3'b010;
      req_id[1] = 8'h25;  req_pc[1] = 32'h0000_0250;
      tick();
      clear_reqs();
      n_checks++;
      if (squash_valid !== 1'b0 || stall !== 1'b1 || squash_id !== 8'h20) begin
         n_fail++;
         $display("FAIL younger_dropped: sv=%b st=%b id=%h expected 0/1/20",
                  squash_valid, stall, squash_id);
      end
      req_valid = 3'b100;
      req_id[2] = 8'h1C;  req_pc[2] = 32'h0000_01C0;
      tick();
      clear_reqs();
      n_checks++;
      if (squash_valid !== 1'b1 || squash_id !== 8'h1C || redirect_pc !== 32'h0000_01C0) begin
         n_fail++;
         $display("FAIL older_preempt: sv=%b id=%h pc=%h expected 1/1c/000001c0",
                  squash_valid, squash_id, redirect_pc);
      end
      finish_drain("preempt");
   endtask

   task automatic test_back_to_back();
      head_id   = 8'h10;
      req_valid = 3'b001;
      req_id[0] = 8'h20;  req_pc[0] = 32'h0000_0200;
      tick();
      req_valid = 3'b010;
      req_id[1] = 8'h18;  req_pc[1] = 32'h0000_0180;
      tick();
      clear_reqs();
      n_checks++;
      if (squash_valid !== 1'b0 || stall !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_gap: sv=%b st=%b expected 0/1", squash_valid, stall);
      end
      tick();
      n_checks++;
      if (squash_valid !== 1'b1 || squash_id !== 8'h18 || redirect_pc !== 32'h0000_0180) begin
         n_fail++;
         $display("FAIL b2b_second: sv=%b id=%h pc=%h expected 1/18/00000180",
                  squash_valid, squash_id, redirect_pc);
      end
      finish_drain("b2b");
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      head_id   = 8'h10;
      req_valid = 3'b001;
      req_id[0] = 8'h12;  req_pc[0] = 32'h8000_0100;
      tick();
      rst       = 1'b1;
      req_valid = 3'b100;
      req_id[2] = 8'h11;  req_pc[2] = 32'h0000_0110;
      tick();
      n_checks++;
      if ({squash_valid, redirect_valid, stall, busy} !== 4'b0 || squash_id !== 8'h00 ||
          redirect_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_abort: sv=%b rv=%b st=%b bz=%b id=%h pc=%h expected all 0",
                  squash_valid, redirect_valid, stall, busy, squash_id, redirect_pc);
      end
      rst = 1'b0;
      clear_reqs();
      for (int i = 0; i < 4; i++) begin
         tick();
         if (squash_valid || busy) pulses++;
      end
      n_checks++;
      if (pulses !== 0) begin
         n_fail++;
         $display("FAIL rst_no_pulse: active cycles=%0d expected 0", pulses);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_oldest();
      test_wrap();
      test_tie();
      test_drop_preempt();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/squash_arbiter.md
SQUASH_ARBITER -- requirements
Module: squash_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of squash requesters (index 0 branch unit, 1 LSU, 2 commit/fault).
REQ-002 Parameter DRAIN_CYCLES, default 2, front-end stall cycles after each squash pulse, legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid_i  input  NREQ  per-requester single-cycle squash request pulse; no backpressure.
REQ-006 req_id_i  input  NREQ x id_t  id of youngest instruction that survives the squash.
REQ-007 req_pc_i  input  NREQ x pc_t  fetch redirect target.
REQ-008 head_id_i  input  id_t  id of oldest in-flight instruction; age reference.
REQ-009 squash_valid_o  output  1  squash broadcast to all stages (drives squash_if valid).
REQ-010 squash_id_o  output  id_t  surviving id; decode restarts numbering at squash_id_o+1.
REQ-011 redirect_valid_o  output  1  fetch redirect strobe.
REQ-012 redirect_pc_o  output  pc_t  fetch redirect target.
REQ-013 stall_o  output  1  front-end hold (fetch/decode ready forced low by consumers).
REQ-014 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-015 Age of id x SHALL be (x - head_id_i) modulo 2^ID_W; smaller age is older; wrap-around of id_t SHALL be handled solely by this subtraction.
REQ-016 Among valid requests in a cycle the oldest SHALL win; equal ages SHALL resolve to lowest index.
REQ-017 FSM states: IDLE, SQUASH, DRAIN.
REQ-018 IDLE: any valid request -> SQUASH next cycle, winner id/pc latched.
REQ-019 SQUASH lasts exactly one cycle: squash_valid_o=1, redirect_valid_o=1, id/pc outputs = latched winner; then -> DRAIN with counter loaded DRAIN_CYCLES-1.
REQ-020 DRAIN: counter decrements each cycle; at 0 with no accepted request -> IDLE.
REQ-021 In SQUASH or DRAIN, a request whose winner age is strictly older than the latched id SHALL be accepted: latch replaced, -> SQUASH next cycle (preemption).
REQ-022 In SQUASH or DRAIN, requests equal-age or younger than latched id SHALL be dropped silently (already squashed).
REQ-023 Latency request-pulse to squash_valid_o SHALL be exactly 1 cycle from IDLE or DRAIN.
REQ-024 squash_valid_o and redirect_valid_o SHALL be high only in SQUASH and always together.
REQ-025 stall_o SHALL be high in SQUASH and DRAIN, low in IDLE.
REQ-026 squash_id_o/redirect_pc_o SHALL hold the last latched value outside SQUASH (don't-care for consumers).
REQ-027 Back-to-back accepted squashes SHALL produce consecutive squash_valid_o pulses separated by at least one DRAIN cycle per REQ-019.

Reset
REQ-028 rst high SHALL force IDLE, counter 0, latched id/pc 0, all outputs 0 on the next edge.
REQ-029 rst asserted mid-SQUASH or mid-DRAIN SHALL abort without emitting further pulses; rst wins over simultaneous requests.
REQ-030 Requests during the reset cycle SHALL be discarded.

Structure
REQ-031 squash_req_t (id_t id, pc_t pc) and squash_state_e (IDLE, SQUASH, DRAIN) SHALL live in package C; id_t and pc_t reused from C.
REQ-032 One combinational sub-module oldest_sel SHALL compute the age-based winner index, valid flag and winner request for NREQ inputs.
REQ-033 The squash_if master port SHALL be driven from squash_valid_o/squash_id_o by the integrating top, not inside this block.

Verification
REQ-034 Idle, req_valid_i[0]=1 id=0x12 pc=0x8000_0100, head=0x10 -> next cycle squash_valid_o=1, squash_id_o=0x12, redirect_pc_o=0x8000_0100; stall_o high for 1+2 cycles, then busy_o=0.
REQ-035 Same cycle reqs [0] id=0x15 and [1] id=0x13, head=0x10 -> squash_id_o=0x13, pc of requester 1; single pulse.
REQ-036 Wrap: head=0xFE (8-bit id), reqs id=0x01 and id=0xFF -> winner 0xFF.
REQ-037 During DRAIN of squash id=0x20: req id=0x25 -> dropped, no pulse; req id=0x1C next -> second pulse squash_id_o=0x1C one cycle later, drain restarts.
REQ-038 Tie: reqs [1] and [2] both id=0x30 -> requester 1 pc selected.
REQ-039 rst asserted cycle after SQUASH pulse -> all outputs 0 next cycle, no further pulses; request in rst cycle ignored.
